// File: rtl/attack_sequencer.sv
// attack_sequencer: turns debounced attack buttons into a timed startup/active/recovery
// sequence and emits a single-clock attack code per landed hit.
module attack_sequencer #(
    parameter int L_STARTUP = 2,
    parameter int L_ACTIVE  = 2,
    parameter int L_RECOVER = 4,
    parameter int M_STARTUP = 4,
    parameter int M_ACTIVE  = 3,
    parameter int M_RECOVER = 8,
    parameter int H_STARTUP = 8,
    parameter int H_ACTIVE  = 4,
    parameter int H_RECOVER = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       btn_light,
    input  logic       btn_medium,
    input  logic       btn_heavy,
    input  logic       in_range,
    output logic [2:0] attack_code,
    output logic       hit_strobe,
    output logic [1:0] anim_type,
    output logic [1:0] anim_phase,
    output logic       busy
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] STARTUP = 2'b01;
    localparam logic [1:0] ACTIVE  = 2'b10;
    localparam logic [1:0] RECOVER = 2'b11;

    logic [1:0]       state, state_n, typ, typ_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       hist, rise;
    logic             hit_done, hit_done_n, hit;

    function automatic logic [CNT_W-1:0] dur(input logic [1:0] ph, input logic [1:0] ty);
        logic [CNT_W-1:0] s, a, r;
        s = ty == 2'd3 ? CNT_W'(H_STARTUP) : ty == 2'd2 ? CNT_W'(M_STARTUP) : CNT_W'(L_STARTUP);
        a = ty == 2'd3 ? CNT_W'(H_ACTIVE)  : ty == 2'd2 ? CNT_W'(M_ACTIVE)  : CNT_W'(L_ACTIVE);
        r = ty == 2'd3 ? CNT_W'(H_RECOVER) : ty == 2'd2 ? CNT_W'(M_RECOVER) : CNT_W'(L_RECOVER);
        return ph == STARTUP ? s : ph == ACTIVE ? a : ph == RECOVER ? r : '0;
    endfunction

    assign rise = {btn_heavy, btn_medium, btn_light} & ~hist;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        typ_n      = typ;
        hit_done_n = hit_done;
        hit        = 1'b0;
        if (state == IDLE) begin
            if (enable && |rise) begin
                state_n = STARTUP;
                typ_n   = rise[2] ? 2'd3 : rise[1] ? 2'd2 : 2'd1;
                cnt_n   = dur(STARTUP, typ_n);
            end
        end else if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            hit        = state == ACTIVE && in_range && !hit_done;
            hit_done_n = hit_done | hit;
            if (frame_tick) begin
                if (cnt == CNT_W'(1)) begin
                    // phase codes are sequential, so RECOVER + 1 wraps to IDLE
                    state_n    = state + 2'd1;
                    cnt_n      = dur(state_n, typ);
                    hit_done_n = state_n == ACTIVE ? 1'b0 : hit_done_n;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            typ         <= 2'd0;
            hist        <= 3'b000;
            hit_done    <= 1'b0;
            attack_code <= 3'b000;
            hit_strobe  <= 1'b0;
            anim_type   <= 2'b00;
            anim_phase  <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            typ         <= typ_n;
            hist        <= {btn_heavy, btn_medium, btn_light};
            hit_done    <= hit_done_n;
            attack_code <= hit ? {1'b0, typ} : 3'b000;
            hit_strobe  <= hit;
            anim_type   <= state_n == IDLE ? 2'b00 : typ_n;
            anim_phase  <= state_n;
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_attack_sequencer.sv
// tb_attack_sequencer: randomized and directed stimulus against a tick-count reference
// model; expected strobes go through a queue popped by an independent monitor.
module tb_attack_sequencer;
    logic       clk = 1'b0;
    logic       reset, frame_tick, enable, btn_light, btn_medium, btn_heavy, in_range;
    logic [2:0] attack_code;
    logic       hit_strobe, busy;
    logic [1:0] anim_type, anim_phase;

    attack_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .btn_light(btn_light), .btn_medium(btn_medium), .btn_heavy(btn_heavy),
        .in_range(in_range), .attack_code(attack_code), .hit_strobe(hit_strobe),
        .anim_type(anim_type), .anim_phase(anim_phase), .busy(busy)
    );

    always #5 clk = ~clk;

    int S[4] = '{0, 2, 4, 8};
    int A[4] = '{0, 2, 3, 4};
    int R[4] = '{0, 4, 8, 16};

    // model: an attack is its type plus the number of frame ticks since it started
    int         m_type = 0, m_ticks = 0;
    logic       m_busy = 1'b0, m_hit = 1'b0;
    logic [2:0] m_hist = 3'b000;
    logic [2:0] exp_q[$];
    int         n_pass = 0, n_total = 0;

    function automatic int phase_of(input int ty, input int ti);
        return ti < S[ty] ? 1 : ti < S[ty] + A[ty] ? 2 : 3;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic drive(input logic r, input logic e, input logic t, input logic [2:0] b, input logic ir);
        logic [2:0] rise;
        reset = r; enable = e; frame_tick = t; in_range = ir;
        {btn_heavy, btn_medium, btn_light} = b;
        rise   = b & ~m_hist;
        m_hist = b;
        if (r) begin
            m_busy = 1'b0; m_type = 0; m_ticks = 0; m_hit = 1'b0; m_hist = 3'b000;
        end else if (!m_busy) begin
            if (e && rise != 3'b000) begin
                m_busy = 1'b1; m_ticks = 0; m_hit = 1'b0;
                m_type = rise[2] ? 3 : rise[1] ? 2 : 1;
            end
        end else if (!e) begin
            m_busy = 1'b0; m_type = 0;
        end else begin
            if (phase_of(m_type, m_ticks) == 2 && ir && !m_hit) begin
                m_hit = 1'b1;
                exp_q.push_back(3'(m_type));
            end
            if (t) begin
                m_ticks++;
                if (m_ticks == S[m_type] + A[m_type] + R[m_type]) begin
                    m_busy = 1'b0; m_type = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("anim_type", {6'd0, anim_type}, m_busy ? 8'(m_type) : 8'd0);
        chk("anim_phase", {6'd0, anim_phase}, m_busy ? 8'(phase_of(m_type, m_ticks)) : 8'd0);
        if (exp_q.size() > 0) begin
            chk("hit_strobe", {7'd0, hit_strobe}, 8'd1);
            chk("attack_code", {5'd0, attack_code}, {5'd0, exp_q.pop_front()});
        end else begin
            chk("hit_strobe", {7'd0, hit_strobe}, 8'd0);
            chk("attack_code", {5'd0, attack_code}, 8'd0);
        end
    end

    initial begin
        logic [2:0] b;
        repeat (2) drive(1, 1, 1, 3'b000, 0);
        for (int i = 0; i < 14; i++) drive(0, 1, 1, i < 12 ? 3'b001 : 3'b000, 1);
        for (int i = 0; i < 32; i++) drive(0, 1, 1, i < 30 ? 3'b101 : 3'b000, 1);
        for (int i = 0; i < 20; i++) drive(0, 1, 1, i < 18 ? 3'b010 : 3'b000, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 1, i < 2 ? 3'b010 : 3'b000, i == 7);
        for (int i = 0; i < 15; i++) drive(0, i != 10, 1, i == 0 ? 3'b100 : 3'b000, i > 10);
        for (int i = 0; i < 12; i++) drive(0, 1, 1, i == 0 ? 3'b001 : 3'b000, 1);
        for (int i = 0; i < 30; i++) drive(i == 22, 1, i % 4 == 0, (i == 0 || i == 2) ? 3'b001 : 3'b000, 1);
        b = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
                  b, $urandom_range(0, 3) == 0);
        end
        repeat (3) drive(1, 1, 1, 3'b000, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
